// File: rtl/rst_seq.sv
// rst_seq: reset sequencer merging power-on, pin, sw and watchdog requests.
// Holds all block resets, then releases them one stage at a time.
module rst_seq #(
  parameter int STAGES   = 3,
  parameter int HOLD_CYC = 200,
  parameter int GAP_CYC  = 16,
  parameter int SYNC_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ext_i,
  input  logic              sw_req_i,
  input  logic              wdog_i,
  input  logic              cause_clr_i,
  output logic [STAGES-1:0] rst_o,
  output logic              busy_o,
  output logic [3:0]        cause_o
);

  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST  = IW'(STAGES - 1);
  localparam logic [IW-1:0] IDX_FIRST = IW'(1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_REL,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              busy_q, busy_d;
  logic [3:0]        cause_q, cause_d;
  logic [SYNC_W-1:0] sync_q, sync_d;

  logic          ext_s;
  logic [3:0]    req_bits;
  logic          req;
  logic [CW-1:0] cnt_inc;

  assign ext_s    = sync_q[SYNC_W-1];
  assign req_bits = {wdog_i, sw_req_i, ext_s, 1'b0};
  assign req      = |req_bits;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // shift the async pin request into the clock domain
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = ext_i;
  end

  // sequencer next state, staged resets and cause tracking
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    unique case (state_q)
      S_HOLD: begin
        rst_d = '1;
        if (req) begin
          cnt_d   = '0;
          cause_d = cause_q | req_bits;
        end else if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (STAGES == 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_REL;
            idx_d   = IDX_FIRST;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REL: begin
        if (req) begin
          rst_d   = '1;
          cnt_d   = '0;
          state_d = S_HOLD;
          cause_d = req_bits;
        end else if (cnt_q == GAP_LAST) begin
          rst_d = rst_q & ~(STAGES'(1) << idx_q);
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        rst_d = '0;
        if (req) begin
          rst_d   = '1;
          cnt_d   = '0;
          state_d = S_HOLD;
          cause_d = req_bits;
        end else if (cause_clr_i) begin
          cause_d = '0;
        end
      end
      default: begin
        rst_d   = '1;
        cnt_d   = '0;
        state_d = S_HOLD;
      end
    endcase
    busy_d = |rst_d;
  end

  // state registers; power-on reset records cause bit 0
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      cause_q <= 4'b0001;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      sync_q  <= sync_d;
    end
  end

  assign rst_o   = rst_q;
  assign busy_o  = busy_q;
  assign cause_o = cause_q;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer: merges power-on, external-pin, software and watchdog reset requests into one stretched reset sequence.
- Releases a set of active-high block resets in a fixed staged order. Stage 0 is released first; stage STAGES-1 is released last.
- Sits at the top level, fed by the synchronized system reset.
- Drives the reset inputs of the core, peripherals and I/O blocks.
- Records which source caused the most recent reset.

Parameters:
- STAGES, 3, number of staged reset outputs (min 1).
- HOLD_CYC, 200, minimum cycles all outputs stay asserted after the last request (min 1).
- GAP_CYC, 16, cycles between successive stage releases (min 1).
- SYNC_W, 2, number of resync flops on ext_i (min 1).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. Asynchronous, active-low. Deassertion is already synchronous to clk_i upstream.
- ext_i  in  1  external reset request. Asynchronous, active-high, level.
- sw_req_i  in  1  software reset request. Synchronous, one-cycle pulse.
- wdog_i  in  1  watchdog expiry. Synchronous, one-cycle pulse.
- cause_clr_i  in  1  clears cause_o. Synchronous pulse.
- rst_o  out  STAGES  staged resets, active-high.
- busy_o  out  1  high while any rst_o bit is high.
- cause_o  out  4  sticky reset cause bits: [0] power-on (rst_n_i), [1] ext, [2] sw, [3] wdog.

Behaviour:
- Reset values while rst_n_i is low:
  - rst_o = all ones, busy_o = 1, cause_o = 4'b0001.
  - state = HOLD, counter = 0.
  - ext sync chain = 0.
- ext_i passes through SYNC_W flops. The request term is ext_s, the last flop.
- req = ext_s | sw_req_i | wdog_i.
- Counter width = $clog2(max(HOLD_CYC, GAP_CYC) + 1). The counter saturates and never wraps.
- State HOLD:
  - All rst_o bits are high.
  - If req is high: counter := 0.
  - Else: counter increments.
  - When the counter reaches HOLD_CYC-1 and req is low:
    - rst_o[0] := 0.
    - counter := 0.
    - Go to RELEASE with stage index = 1, or to RUN if STAGES == 1.
- State RELEASE:
  - The counter increments each cycle.
  - When it reaches GAP_CYC-1: rst_o[idx] := 0, counter := 0, idx++.
  - After rst_o[STAGES-1] is released, go to RUN.
- State RUN:
  - rst_o = 0, busy_o = 0.
- A req in RELEASE or RUN:
  - Next cycle rst_o = all ones, busy_o = 1, counter = 0, state = HOLD.
- Latency:
  - sw_req_i or wdog_i high at edge t gives rst_o all ones after edge t.
  - ext_i high at least one cycle before edge t gives rst_o high SYNC_W edges later.
- Release timing from the last cycle req is high (edge t):
  - rst_o[0] falls after edge t + HOLD_CYC.
  - rst_o[k] falls after edge t + HOLD_CYC + k·GAP_CYC.
- Release timing from rst_n_i deassertion: rst_o[0] falls after the HOLD_CYC-th rising edge.
- ext_s held high keeps the sequencer in HOLD indefinitely.
- busy_o = |rst_o, registered alongside rst_o with no extra latency.
- Cause register:
  - A req seen while in RUN or RELEASE: cause_o := request bits {wdog, sw, ext, 0}. Prior causes are discarded.
  - A req seen while in HOLD: the request bits are OR'd into cause_o.
  - cause_clr_i is honoured only in RUN and sets cause_o := 0.
  - cause_clr_i and req in the same cycle: req wins; the clear is ignored.
- Simultaneous sources: all asserted sources are recorded in cause_o.
- rst_n_i asserting at any point, mid-HOLD or mid-RELEASE, returns immediately to the reset values.

Test Plan (STAGES=3, HOLD_CYC=8, GAP_CYC=4, SYNC_W=2):
- Power-on:
  - Stimulus: drop rst_n_i, then release it at edge 0.
  - Required: rst_o=3'b111 and cause_o=4'b0001 during reset; rst_o[0] falls after edge 8, rst_o[1] after edge 12, rst_o[2] after edge 16; busy_o falls with rst_o[2].
- sw reset in RUN:
  - Stimulus: sw_req_i pulse at edge 30.
  - Required: rst_o=3'b111 after edge 30; cause_o=4'b0100; rst_o[0] falls after edge 38, rst_o[2] after edge 46.
- Extend during HOLD:
  - Stimulus: sw_req_i at edge 50, wdog_i at edge 54.
  - Required: cause_o=4'b1100; rst_o[0] falls after edge 62.
- Request mid-RELEASE:
  - Stimulus: wdog_i one edge after rst_o[0] falls.
  - Required: rst_o returns to 3'b111 next cycle; cause_o=4'b1000; the full sequence restarts.
- ext level:
  - Stimulus: hold ext_i high for 20 cycles from a RUN state.
  - Required: rst_o asserts 2 edges after ext_i rises; rst_o[0] falls 8 edges after the last edge ext_s is high; cause_o=4'b0010.
- Clear behaviour:
  - cause_clr_i in RUN gives cause_o=0.
  - cause_clr_i together with sw_req_i gives cause_o=4'b0100.
  - cause_clr_i during HOLD leaves cause_o unchanged.
  - rst_n_i asserted mid-RELEASE gives rst_o=3'b111 and cause_o=4'b0001 immediately, with no clock.
